ripple_counter_seq: RTL and testbench

Sequencer that owns a WIDTH-bit asynchronous ripple counter and advances it safely from a single synchronous clock domain. On request, it clears the counter and issues clock pulses until the target count is reached. After each pulse it waits a programmable settle window for ripple propagation, then checks the counter output against a shadow count. It sits between a requesting controller and the ripple counter instance, driving that counter's clk and rst pins.

---
 rtl/ripple_counter_seq.sv | 101 ++++++++++
 tb/tb_ripple_counter_seq.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/ripple_counter_seq.sv
// Sequencer for an external WIDTH-bit ripple counter: clears it, pulses it up to a
// target count, and verifies each step against a shadow count after a settle window.
module ripple_counter_seq #(
    parameter int WIDTH      = 4,
    parameter int RST_CYC    = 2,
    parameter int SETTLE_CYC = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [WIDTH-1:0] target,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [WIDTH-1:0] err_exp,
    output logic [WIDTH-1:0] result,
    output logic             cnt_clk,
    output logic             cnt_rst,
    input  logic [WIDTH-1:0] cnt_q
);

    typedef enum logic [2:0] {
        IDLE, CLEAR, CHECK, PULSE, LOW, SETTLE, DONE, ERR
    } state_t;

    localparam int CMAX = (RST_CYC > SETTLE_CYC) ? RST_CYC : SETTLE_CYC;
    localparam int CW   = $clog2(CMAX + 1);

    state_t           state, state_nxt;
    logic [CW-1:0]    cyc;
    logic [WIDTH-1:0] tgt, shadow;
    logic             state_busy;

    assign state_busy = (state == CLEAR) || (state == CHECK) || (state == PULSE) ||
                        (state == LOW)   || (state == SETTLE);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start && !abort) state_nxt = CLEAR;
            CLEAR:   if (cyc == CW'(RST_CYC - 1)) state_nxt = CHECK;
            CHECK: begin
                if (cnt_q != shadow)    state_nxt = ERR;
                else if (shadow == tgt) state_nxt = DONE;
                else                    state_nxt = PULSE;
            end
            PULSE:   state_nxt = LOW;
            LOW:     state_nxt = SETTLE;
            SETTLE:  if (cyc == CW'(SETTLE_CYC - 1)) state_nxt = CHECK;
            DONE:    state_nxt = IDLE;
            ERR:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        // DONE and ERR are not in the busy set, so their one-cycle pulse always completes
        if (abort && state_busy) state_nxt = IDLE;
    end

    // Outputs are registered decodes of the next state, so they line up with state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cyc     <= '0;
            tgt     <= '0;
            shadow  <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;
            err_exp <= '0;
            result  <= '0;
            cnt_clk <= 1'b0;
        end else begin
            state   <= state_nxt;
            busy    <= (state_nxt == CLEAR) || (state_nxt == CHECK) || (state_nxt == PULSE) ||
                       (state_nxt == LOW)   || (state_nxt == SETTLE);
            done    <= (state_nxt == DONE);
            cnt_clk <= (state_nxt == PULSE);

            if ((state_nxt == state) && ((state == CLEAR) || (state == SETTLE)))
                cyc <= cyc + 1'b1;
            else
                cyc <= '0;

            if (state == IDLE && state_nxt == CLEAR) begin
                tgt    <= target;
                shadow <= '0;
                err    <= 1'b0;
            end
            if (state == CHECK) result <= cnt_q;
            if (state == PULSE) shadow <= shadow + 1'b1;
            if (state_nxt == ERR) begin
                err     <= 1'b1;
                err_exp <= shadow;
            end
        end
    end

    // Combinational so the counter is held cleared for the whole time rst is high.
    assign cnt_rst = rst || (state == CLEAR);

endmodule

// File: tb/tb_ripple_counter_seq.sv
// Randomized bench for ripple_counter_seq with an attached ripple-counter model
// (optional stuck-at-0 bits) and a schedule-based reference model.
module tb_ripple_counter_seq;
    localparam int W  = 4;
    localparam int R  = 2;
    localparam int S  = 2;
    localparam int S3 = S + 3;

    logic         clk = 1'b0;
    logic         rst, start, abort;
    logic [W-1:0] target, err_exp, result, cnt_q;
    logic         busy, done, err, cnt_clk, cnt_rst;
    logic [W-1:0] ctr = '0;
    logic [W-1:0] stuck = '0;

    int vectors = 0, miscompares = 0, cyc_n = 0, start_cyc = 0;
    int done_rel = -1, pulses = 0;
    bit chk_en = 1'b0;

    // reference model: sequence described as an offset k from the first CLEAR cycle
    bit           m_act = 1'b0, m_bad = 1'b0, m_err = 1'b0;
    int           m_k = 0, m_end = 0, m_jbad = 0;
    logic [W-1:0] m_errexp = '0, m_res = '0;

    always #5 clk = ~clk;

    ripple_counter_seq #(.WIDTH(W), .RST_CYC(R), .SETTLE_CYC(S)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .target(target),
        .busy(busy), .done(done), .err(err), .err_exp(err_exp), .result(result),
        .cnt_clk(cnt_clk), .cnt_rst(cnt_rst), .cnt_q(cnt_q)
    );

    always @(posedge cnt_clk or posedge cnt_rst)
        if (cnt_rst) ctr <= '0;
        else         ctr <= ctr + 1'b1;
    assign cnt_q = ctr & ~stuck;

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc_n);
        end
    endtask

    always @(posedge clk) begin
        cyc_n++;
        if (rst) begin
            m_act = 0; m_err = 0; m_errexp = '0; m_res = '0;
        end else if (m_act) begin
            if (m_k >= R + 1 && (m_k - (R + 1)) % S3 == 0 && m_k < m_end)
                m_res = W'((m_k - (R + 1)) / S3) & ~stuck;
            if (m_k == m_end) m_act = 0;
            else if (abort)   m_act = 0;
            else begin
                m_k++;
                if (m_k == m_end && m_bad) begin
                    m_err = 1; m_errexp = W'(m_jbad);
                end
            end
        end else if (start && !abort) begin
            m_act = 1; m_k = 1; m_err = 0; m_bad = 0; m_jbad = 0;
            // first step whose count has a stuck bit set reads back wrong
            for (int j = 0; j <= int'(target); j++)
                if (!m_bad && ((W'(j) & stuck) != '0)) begin
                    m_bad = 1; m_jbad = j;
                end
            m_end = R + 2 + (m_bad ? m_jbad : int'(target)) * S3;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            cmp("busy",    busy,    m_act && m_k < m_end);
            cmp("done",    done,    m_act && m_k == m_end && !m_bad);
            cmp("cnt_clk", cnt_clk, m_act && m_k >= R + 2 && m_k < m_end && (m_k - (R + 2)) % S3 == 0);
            cmp("cnt_rst", cnt_rst, rst || (m_act && m_k <= R));
            cmp("err",     err,     m_err);
            cmp("err_exp", err_exp, m_errexp);
            cmp("result",  result,  m_res);
            if (done)    done_rel = cyc_n - start_cyc + 1;
            if (cnt_clk) pulses++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [W-1:0] t);
        start = 1; target = t;
        tick();
        start = 0;
        start_cyc = cyc_n; done_rel = -1; pulses = 0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((busy || m_act) && n < 200) begin
            tick(); n++;
        end
        cmp("wait_idle_timeout", n < 200, 1);
    endtask

    initial begin
        rst = 1; start = 0; abort = 0; target = '0;
        tick();
        chk_en = 1;
        tick();
        cmp("rst_cnt_rst", cnt_rst, 1);
        tick();
        rst = 0;
        tick();
        cmp("rel_busy", busy, 0);
        cmp("rel_cnt_rst", cnt_rst, 0);
        cmp("rel_err", err, 0);

        // target 0: clear, one check, done in cycle R+2
        do_start(0);
        repeat (5) tick();
        cmp("t0_done_cycle", done_rel, 4);
        cmp("t0_pulses", pulses, 0);
        cmp("t0_result", result, 0);

        // target 3: pulses at 4, 9, 14; done in cycle 19
        do_start(3);
        repeat (20) tick();
        cmp("t3_done_cycle", done_rel, 19);
        cmp("t3_pulses", pulses, 3);
        cmp("t3_result", result, 3);
        cmp("t3_err", err, 0);

        // Q[2] stuck at 0: mismatch when shadow reaches 4
        stuck = 4'b0100;
        do_start(15);
        wait_idle();
        cmp("stuck_err", err, 1);
        cmp("stuck_err_exp", err_exp, 4);
        cmp("stuck_result", result, 0);
        cmp("stuck_no_done", done_rel, -1);
        cmp("stuck_pulses", pulses, 4);
        stuck = '0;
        do_start(1);
        cmp("restart_clears_err", err, 0);
        wait_idle();

        // abort in the second SETTLE (cycle 11)
        do_start(5);
        repeat (10) tick();
        abort = 1;
        tick();
        abort = 0;
        cmp("abort_busy", busy, 0);
        repeat (10) tick();
        cmp("abort_pulses", pulses, 2);
        cmp("abort_no_done", done_rel, -1);
        start = 1; abort = 1; target = 3;
        tick();
        start = 0; abort = 0;
        cmp("start_abort_idle", busy, 0);
        tick();

        // rst during the second PULSE (cycle 9)
        do_start(7);
        repeat (8) tick();
        cmp("pulse_before_rst", cnt_clk, 1);
        rst = 1;
        tick();
        rst = 0;
        cmp("rst_mid_busy", busy, 0);
        cmp("rst_mid_cnt_clk", cnt_clk, 0);
        cmp("rst_mid_cnt_q", cnt_q, 0);
        do_start(2);
        wait_idle();
        cmp("after_rst_done_cycle", done_rel, 14);

        // random traffic against the model
        repeat (4000) begin
            rst    = ($urandom_range(0, 199) == 0);
            abort  = ($urandom_range(0, 59) == 0);
            start  = ($urandom_range(0, 3) == 0);
            target = W'($urandom);
            if (!m_act && start)
                stuck = ($urandom_range(0, 3) == 0) ? W'(1 << $urandom_range(0, W - 1)) : '0;
            tick();
        end
        rst = 0; abort = 0; start = 0;
        wait_idle();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
